// File: rtl/iact_router_stream_tx_pkg.sv
// Shared widths, channel tags and FSM encoding for the iact router transmit path.
package iact_stream_pkg;
  localparam int unsigned IACT_ADDR_W  = 8;
  localparam int unsigned IACT_DATA_W  = 13;
  localparam int unsigned IACT_ENTRY_W = IACT_DATA_W + 1;

  typedef enum logic { TAG_ADDR = 1'b0, TAG_DATA = 1'b1 } iact_tag_e;

  typedef enum logic [1:0] { IDLE, ADDR, DATA, DRAIN } iact_state_e;
endpackage

// File: rtl/iact_router_stream_tx_if.sv
// iact link toward the PE cluster: address/data valid+bits pairs and the row ready.
interface iact_router_stream_tx_if;
  import iact_stream_pkg::*;

  logic                   pe_ready;
  logic                   iact_address_out_valid;
  logic [IACT_ADDR_W-1:0] iact_address_out_bits;
  logic                   iact_data_out_valid;
  logic [IACT_DATA_W-1:0] iact_data_out_bits;

  modport master (
    input  pe_ready,
    output iact_address_out_valid, iact_address_out_bits,
    output iact_data_out_valid, iact_data_out_bits
  );

  modport slave (
    output pe_ready,
    input  iact_address_out_valid, iact_address_out_bits,
    input  iact_data_out_valid, iact_data_out_bits
  );
endinterface

// File: rtl/iact_router_stream_tx_fifo.sv
// Two-entry synchronous FIFO used as the skid buffer between SRAM read data and the PE link.
module iact_skid_fifo2 #(
  parameter int unsigned W = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);
  logic [W-1:0] mem_q [2];
  logic         wptr_q, rptr_q;
  logic [1:0]   count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
endmodule

// File: rtl/iact_router_stream_tx.sv
// Reads one compressed iact column-group (address vector then data vector) from the GLB
// SRAMs and streams it to the PE row through a 2-entry skid buffer with back-pressure.
module iact_router_stream_tx
  import iact_stream_pkg::*;
#(
  parameter int unsigned ADDR_AW = 5,
  parameter int unsigned DATA_AW = 7,
  parameter int unsigned LEN_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_AW-1:0]     addr_base,
  input  logic [LEN_W-1:0]       addr_len,
  input  logic [DATA_AW-1:0]     data_base,
  input  logic [LEN_W-1:0]       data_len,
  output logic                   busy,
  output logic                   done,
  output logic                   addr_sram_ren,
  output logic [ADDR_AW-1:0]     addr_sram_raddr,
  input  logic [IACT_ADDR_W-1:0] addr_sram_rdata,
  output logic                   data_sram_ren,
  output logic [DATA_AW-1:0]     data_sram_raddr,
  input  logic [IACT_DATA_W-1:0] data_sram_rdata,
  iact_router_stream_tx_if.master pe
);
  localparam logic [LEN_W-1:0] LEN_ONE = 1;
  localparam logic [LEN_W:0]   CNT_ONE = 1;

  iact_state_e          state_q, state_d;
  logic [ADDR_AW-1:0]   abase_q, abase_d;
  logic [DATA_AW-1:0]   dbase_q, dbase_d;
  logic [LEN_W-1:0]     alen_q, alen_d, dlen_q, dlen_d, icnt_q, icnt_d;
  logic [LEN_W:0]       pcnt_q, pcnt_d, total;
  logic                 infl_q;
  iact_tag_e            infl_tag_q;

  logic [IACT_ENTRY_W-1:0] fifo_wdata, fifo_rdata;
  logic                    fifo_full, fifo_empty, pop, credit_ok;
  logic [1:0]              fifo_count;
  logic [2:0]              occ_sum;
  iact_tag_e               head_tag;
  logic                    a_ren, d_ren, done_c;

  assign head_tag = iact_tag_e'(fifo_rdata[IACT_ENTRY_W-1]);
  assign pop      = !fifo_empty && pe.pe_ready;
  assign total    = {1'b0, alen_q} + {1'b0, dlen_q};

  // A read issued now lands in the FIFO one cycle later; a pop this cycle frees one slot in time.
  assign occ_sum   = {1'b0, fifo_count} + {2'b0, infl_q};
  assign credit_ok = pop ? (occ_sum < 3'd3) : (!fifo_full && occ_sum < 3'd2);

  always_comb begin
    state_d = state_q;
    abase_d = abase_q;
    dbase_d = dbase_q;
    alen_d  = alen_q;
    dlen_d  = dlen_q;
    icnt_d  = icnt_q;
    pcnt_d  = pcnt_q + {{LEN_W{1'b0}}, pop};
    a_ren   = 1'b0;
    d_ren   = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          abase_d = addr_base;
          dbase_d = data_base;
          alen_d  = (addr_len == '0) ? LEN_ONE : addr_len;
          dlen_d  = data_len;
          icnt_d  = '0;
          pcnt_d  = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (credit_ok) begin
          a_ren = 1'b1;
          if (icnt_q == alen_q - LEN_ONE) begin
            icnt_d  = '0;
            state_d = (dlen_q == '0) ? DRAIN : DATA;
          end else begin
            icnt_d = icnt_q + LEN_ONE;
          end
        end
      end
      DATA: begin
        if (credit_ok) begin
          d_ren = 1'b1;
          if (icnt_q == dlen_q - LEN_ONE) begin
            icnt_d  = '0;
            state_d = DRAIN;
          end else begin
            icnt_d = icnt_q + LEN_ONE;
          end
        end
      end
      DRAIN: begin
        if (pop && (pcnt_q + CNT_ONE) == total) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      abase_q    <= '0;
      dbase_q    <= '0;
      alen_q     <= '0;
      dlen_q     <= '0;
      icnt_q     <= '0;
      pcnt_q     <= '0;
      infl_q     <= 1'b0;
      infl_tag_q <= TAG_ADDR;
    end else begin
      state_q    <= state_d;
      abase_q    <= abase_d;
      dbase_q    <= dbase_d;
      alen_q     <= alen_d;
      dlen_q     <= dlen_d;
      icnt_q     <= icnt_d;
      pcnt_q     <= pcnt_d;
      infl_q     <= a_ren || d_ren;
      infl_tag_q <= d_ren ? TAG_DATA : TAG_ADDR;
    end
  end

  assign fifo_wdata = (infl_tag_q == TAG_DATA)
                    ? {1'b1, data_sram_rdata}
                    : {1'b0, {(IACT_DATA_W-IACT_ADDR_W){1'b0}}, addr_sram_rdata};

  iact_skid_fifo2 #(.W(IACT_ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (infl_q),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign busy            = (state_q != IDLE);
  assign done            = done_c;
  assign addr_sram_ren   = a_ren;
  assign addr_sram_raddr = a_ren ? abase_q + icnt_q[ADDR_AW-1:0] : '0;
  assign data_sram_ren   = d_ren;
  assign data_sram_raddr = d_ren ? dbase_q + icnt_q[DATA_AW-1:0] : '0;

  assign pe.iact_address_out_valid = !fifo_empty && head_tag == TAG_ADDR;
  assign pe.iact_data_out_valid    = !fifo_empty && head_tag == TAG_DATA;
  assign pe.iact_address_out_bits  = pe.iact_address_out_valid ? fifo_rdata[IACT_ADDR_W-1:0] : '0;
  assign pe.iact_data_out_bits     = pe.iact_data_out_valid ? fifo_rdata[IACT_DATA_W-1:0] : '0;
endmodule
